td4_prog_mem: RTL and testbench
===============================

Name: td4_prog_mem

Overview:
- Parametrised program memory for the TD4 core. Replaces the fixed hard-wired instruction table.
- Provides a CPU fetch port with selectable combinational or registered read.
- Provides a runtime loader (valid/ready word stream, managed by an FSM) so a program can be written without resynthesis.
- While a load is in progress the block asserts cpu_hold and feeds the CPU a safe instruction.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- REG_OUT, 0, 0 = combinational fetch (qd follows adr in the same cycle); 1 = registered fetch (1-cycle latency).
- FILL_WORD, 8'hF0, word written to every location on reset (TD4 "JMP 0").

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- adr  in  ADDR_W  CPU fetch address.
- qd  out  DATA_W  fetched instruction.
- cpu_hold  out  1  high while the loader owns memory; the CPU must not advance.
- ld_start  in  1  request a new load; sampled only in IDLE.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  program word.
- ld_last  in  1  marks the final word of the load; qualified by the handshake.
- ld_ready  out  1  loader accepts a word this cycle.
- ld_done  out  1  single-cycle pulse when a load completes.
- ld_count  out  ADDR_W+1  number of words written by the current or most recent load.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All DEPTH locations are set to FILL_WORD.
  - FSM goes to IDLE; write pointer = 0; ld_count = 0.
  - ld_ready = 0, ld_done = 0, cpu_hold = 0.
  - qd = FILL_WORD: registered when REG_OUT=1, combinationally via the memory contents when REG_OUT=0.
  - A reset during a load aborts it; partially written words are overwritten by the fill.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_ready = 0; ld_valid is ignored. ld_start=1 -> LOAD, with write pointer and ld_count cleared to 0.
  - LOAD: ld_ready = 1 and cpu_hold = 1. On ld_valid & ld_ready:
    - mem[ptr] <= ld_data; ptr increments; ld_count increments.
    - If ld_last=1, or ptr = DEPTH-1 (the DEPTH-th word), the next state is DONE. The pointer never wraps.
    - ld_valid=0 leaves the state unchanged; there is no timeout.
  - DONE: exactly one cycle. ld_done = 1, ld_ready = 0, cpu_hold = 1. Next state is IDLE.
- ld_start outside IDLE is ignored. A ld_start held high in IDLE restarts a load on the cycle after DONE.
- Locations not written by a load keep their previous contents.
- ld_count holds its final value in IDLE until the next ld_start.
- Fetch path:
  - REG_OUT=0: qd = cpu_hold ? FILL_WORD : mem[adr], purely combinational.
  - REG_OUT=1: qd <= cpu_hold ? FILL_WORD : mem[adr] on each edge. Data for adr at cycle n appears at cycle n+1.
  - Read/write to the same address in the same cycle: the fetch returns FILL_WORD (hold is active), never the new word.
- cpu_hold rises in the cycle the FSM enters LOAD and falls in the first IDLE cycle after DONE.
- Widths: ld_count is ADDR_W+1 bits so that DEPTH is representable. Arithmetic is unsigned with no overflow, because the pointer stops at DEPTH-1.

Optional Feature:
- Macro: TD4_PROG_MEM_CHECKSUM_EN.
- Defined:
  - Adds output port ld_sum, DATA_W bits.
  - ld_sum is cleared to 0 on reset and on the ld_start acceptance edge.
  - On each accepted word, ld_sum <= ld_sum + ld_data (mod 2**DATA_W).
  - ld_sum is stable from the DONE cycle until the next accepted ld_start.
- Undefined: the ld_sum port and its adder are absent; all other behaviour is identical.

Test Plan:
- Reset, REG_OUT=0: rst=1 for one edge, then sweep adr 0..15 -> qd=8'hF0 at every address; cpu_hold=0, ld_ready=0, ld_count=0.
- Full load without ld_last, REG_OUT=0:
  - Stimulus: ld_start, then 16 words 8'h00..8'h0F with ld_valid held high.
  - Response: ld_ready high for 16 cycles; ld_done pulses once on the next cycle; ld_count=16; cpu_hold low afterwards; adr=5 -> qd=8'h05.
- Short load with ld_last and backpressure gaps:
  - Stimulus: load 8'hB3, 8'hB6, 8'hB1 with ld_valid low between words; ld_last on the third word.
  - Response: ld_count=3; mem[0..2] updated; mem[3..15] still 8'hF0; qd during the load = 8'hF0 for any adr.
- Reset mid-load: rst after 2 of 5 words -> FSM in IDLE, ld_ready=0, cpu_hold=0, all locations 8'hF0; the following ld_valid pulses have no effect.
- REG_OUT=1 latency and stray inputs:
  - adr changes 0->7 at cycle n -> qd shows mem[7] at n+1.
  - ld_start during LOAD is ignored: exactly one ld_done pulse.
  - ld_valid in IDLE writes nothing.
- With TD4_PROG_MEM_CHECKSUM_EN: load 8'hF0, 8'h20, 8'h01 (ld_last) -> ld_sum=8'h11; a new ld_start clears it to 8'h00.

Source files
------------

// File: rtl/td4_prog_mem.sv
// TD4 program memory: fetch port (comb or 1-cycle registered via REG_OUT) plus a valid/ready runtime loader that holds the CPU while writing.
// Optional load checksum output ld_sum when TD4_PROG_MEM_CHECKSUM_EN is defined; loader only stalls by withholding ld_ready outside LOAD.
module td4_prog_mem #(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           ADDR_W    = 4,
  parameter bit                    REG_OUT   = 1'b0,
  parameter logic [DATA_W-1:0]     FILL_WORD = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] qd,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
`ifdef TD4_PROG_MEM_CHECKSUM_EN
  ,output logic [DATA_W-1:0] ld_sum
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   ptr;
  logic                wr;
  logic                start;

  assign start = (state == IDLE) && ld_start;
  assign wr    = ld_valid && ld_ready;

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_done   = 1'b0;
    cpu_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        // The DEPTH-th word ends the load even without ld_last.
        if (ld_valid && (ld_last || (&ptr))) state_nxt = DONE;
      end
      DONE: begin
        ld_done   = 1'b1;
        cpu_hold  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      ld_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL_WORD;
    end else begin
      state <= state_nxt;
      if (start) begin
        ptr      <= '0;
        ld_count <= '0;
      end else if (wr) begin
        mem[ptr] <= ld_data;
        if (!(&ptr)) ptr <= ptr + 1'b1;
        ld_count <= ld_count + 1'b1;
      end
    end
  end

`ifdef TD4_PROG_MEM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start) ld_sum <= '0;
    else if (wr)      ld_sum <= ld_sum + ld_data;
  end
`endif

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk) begin
        if (rst || cpu_hold) qd <= FILL_WORD;
        else                 qd <= mem[adr];
      end
    end else begin : g_comb_out
      always_comb begin
        qd = cpu_hold ? FILL_WORD : mem[adr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_td4_prog_mem.sv
// Directed bench: a combinational-fetch and a registered-fetch instance share one stimulus stream.
module tb_td4_prog_mem;
  logic       clk;
  logic       rst;
  logic [3:0] adr;
  logic       ld_start, ld_valid, ld_last;
  logic [7:0] ld_data;

  logic [7:0] qd0, qd1;
  logic       hold0, hold1, rdy0, rdy1, done0, done1;
  logic [4:0] cnt0, cnt1;
`ifdef TD4_PROG_MEM_CHECKSUM_EN
  logic [7:0] sum0, sum1;
`endif

  int total = 0;
  int bad   = 0;
  int pulses;
  logic [7:0] w [3];
  logic [7:0] exp8;

  td4_prog_mem #(.DATA_W(8), .ADDR_W(4), .REG_OUT(1'b0), .FILL_WORD(8'hF0)) dut0 (
    .clk(clk), .rst(rst), .adr(adr), .qd(qd0), .cpu_hold(hold0),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy0), .ld_done(done0), .ld_count(cnt0)
`ifdef TD4_PROG_MEM_CHECKSUM_EN
    , .ld_sum(sum0)
`endif
  );

  td4_prog_mem #(.DATA_W(8), .ADDR_W(4), .REG_OUT(1'b1), .FILL_WORD(8'hF0)) dut1 (
    .clk(clk), .rst(rst), .adr(adr), .qd(qd1), .cpu_hold(hold1),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy1), .ld_done(done1), .ld_count(cnt1)
`ifdef TD4_PROG_MEM_CHECKSUM_EN
    , .ld_sum(sum1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    w[0] = 8'hB3; w[1] = 8'hB6; w[2] = 8'hB1;
    rst = 1'b1; adr = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;

    // Reset state
    tick();
    rst = 1'b0;
    #1;
    chk("rst_hold", {31'd0, hold0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_count", {27'd0, cnt0}, 32'd0);
    chk("rst_qd_reg", {24'd0, qd1}, 32'hF0);
    for (int a = 0; a < 16; a++) begin
      adr = 4'(a);
      #1;
      chk($sformatf("rst_qd_%0d", a), {24'd0, qd0}, 32'hF0);
    end

    // Full 16-word load without ld_last
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      #1;
      chk($sformatf("full_ready_%0d", i), {31'd0, rdy0}, 32'd1);
      tick();
    end
    ld_valid = 1'b0;
    #1;
    chk("full_done", {31'd0, done0}, 32'd1);
    chk("full_done_ready", {31'd0, rdy0}, 32'd0);
    chk("full_done_hold", {31'd0, hold0}, 32'd1);
    chk("full_count", {27'd0, cnt0}, 32'd16);
    tick();
    chk("full_idle_done", {31'd0, done0}, 32'd0);
    chk("full_idle_hold", {31'd0, hold0}, 32'd0);
    chk("full_idle_count", {27'd0, cnt0}, 32'd16);
    adr = 4'd5;
    #1;
    chk("full_qd5", {24'd0, qd0}, 32'h05);

    // Short load with ld_last and gaps, from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    adr = 4'd1;
    #1;
    chk("short_hold_qd", {24'd0, qd0}, 32'hF0);
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1;
      ld_data  = w[k];
      ld_last  = (k == 2);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (k < 2) begin
        tick();
        chk($sformatf("short_gap_ready_%0d", k), {31'd0, rdy0}, 32'd1);
        chk($sformatf("short_gap_done_%0d", k), {31'd0, done0}, 32'd0);
        chk($sformatf("short_gap_qd_%0d", k), {24'd0, qd0}, 32'hF0);
      end
    end
    chk("short_done", {31'd0, done0}, 32'd1);
    chk("short_count", {27'd0, cnt0}, 32'd3);
    tick();
    for (int a = 0; a < 16; a++) begin
      adr = 4'(a);
      #1;
      exp8 = (a < 3) ? w[a] : 8'hF0;
      chk($sformatf("short_mem_%0d", a), {24'd0, qd0}, {24'd0, exp8});
    end

    // Reset in the middle of a load
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h11;
    tick();
    ld_data = 8'h22;
    tick();
    rst = 1'b1; ld_data = 8'h33;
    tick();
    rst = 1'b0; ld_data = 8'h44;
    chk("mid_ready", {31'd0, rdy0}, 32'd0);
    chk("mid_hold", {31'd0, hold0}, 32'd0);
    chk("mid_count", {27'd0, cnt0}, 32'd0);
    tick(); tick(); tick();
    ld_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      adr = 4'(a);
      #1;
      chk($sformatf("mid_mem_%0d", a), {24'd0, qd0}, 32'hF0);
    end
    chk("mid_count_after", {27'd0, cnt0}, 32'd0);

    // Stray ld_start during LOAD, then registered-fetch latency
    pulses = 0;
    ld_start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h10 + 8'(i);
      ld_last  = (i == 7);
      ld_start = (i < 7);
      #1;
      if (done0) pulses++;
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (done0) pulses++;
      tick();
    end
    chk("stray_start_pulses", pulses, 32'd1);
    chk("stray_count", {27'd0, cnt0}, 32'd8);
    chk("stray_hold", {31'd0, hold0}, 32'd0);

    adr = 4'd0;
    tick();
    chk("reg_qd0", {24'd0, qd1}, 32'h10);
    adr = 4'd7;
    #1;
    chk("reg_qd_before_edge", {24'd0, qd1}, 32'h10);
    chk("comb_qd7", {24'd0, qd0}, 32'h17);
    tick();
    chk("reg_qd7", {24'd0, qd1}, 32'h17);

    // ld_valid while IDLE writes nothing
    ld_valid = 1'b1; ld_data = 8'hAA;
    tick(); tick();
    ld_valid = 1'b0;
    adr = 4'd0;
    #1;
    chk("idle_valid_mem0", {24'd0, qd0}, 32'h10);
    adr = 4'd8;
    #1;
    chk("idle_valid_mem8", {24'd0, qd0}, 32'hF0);
    chk("idle_valid_count", {27'd0, cnt0}, 32'd8);

`ifdef TD4_PROG_MEM_CHECKSUM_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sum_rst", {24'd0, sum0}, 32'h00);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hF0;
    tick();
    ld_data = 8'h20;
    tick();
    ld_data = 8'h01; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("sum_done", {24'd0, sum0}, 32'h11);
    tick();
    chk("sum_idle", {24'd0, sum0}, 32'h11);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("sum_cleared", {24'd0, sum0}, 32'h00);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 8'h05;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
